mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width of all address ports.
REQ-002 SHALL have parameter: DATA_W, 32, data width of all data ports.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: i_req  input  1  instruction-fetch read request.
REQ-006 SHALL have port: i_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port: i_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port: i_rdata  output  DATA_W  fetch data, valid while i_ack=1.
REQ-009 SHALL have port: d_req  input  1  data-port request (load or store).
REQ-010 SHALL have port: d_we  input  1  1=store, 0=load.
REQ-011 SHALL have port: d_addr  input  ADDR_W  data address.
REQ-012 SHALL have port: d_wdata  input  DATA_W  store data.
REQ-013 SHALL have port: d_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port: d_rdata  output  DATA_W  load data, valid while d_ack=1.
REQ-015 SHALL have port: mem_addr  output  ADDR_W  address to main memory.
REQ-016 SHALL have port: mem_read_en  output  1  memory read enable.
REQ-017 SHALL have port: mem_write_en  output  1  memory write enable.
REQ-018 SHALL have port: mem_wdata  output  DATA_W  memory write data.
REQ-019 SHALL have port: mem_rdata  input  DATA_W  combinational memory read data.

Function
REQ-020 SHALL implement FSM states IDLE, SERVE, RESP; any unencoded state SHALL go to IDLE next cycle.
REQ-021 In IDLE with no request, SHALL stay in IDLE.
REQ-022 In IDLE with at least one request, SHALL grant one requester and latch its address, we (0 for fetch) and wdata, then go to SERVE.
REQ-023 With exactly one request pending, SHALL grant that requester.
REQ-024 With both requests pending, SHALL grant the requester not granted most recently; last-grant flag resets to "data", so first contention grants fetch.
REQ-025 In SERVE (exactly one cycle), SHALL drive mem_addr and mem_wdata from latches, and SHALL assert mem_read_en=1, mem_write_en=0 for reads, or mem_write_en=1, mem_read_en=0 for stores.
REQ-026 At the end of a read SERVE cycle, SHALL register mem_rdata into the granted port's rdata register; a store SHALL leave d_rdata unchanged.
REQ-027 SHALL go from SERVE to RESP and pulse the granted port's ack for exactly one cycle there; RESP SHALL then go to IDLE.
REQ-028 Latency SHALL be request sampled in IDLE at cycle N, memory access in N+1, ack in N+2; peak throughput is one transaction per 3 cycles.
REQ-029 Requests SHALL be sampled only in IDLE; req levels in SERVE/RESP SHALL be ignored.
REQ-030 Req still high in the IDLE cycle after ack SHALL start a new transaction (back-to-back).
REQ-031 Deassertion of req after grant SHALL NOT cancel the transaction; ack still pulses.
REQ-032 Outside SERVE, mem_read_en and mem_write_en SHALL be 0; mem_addr/mem_wdata SHALL hold the latched values.
REQ-033 i_ack and d_ack SHALL never be asserted in the same cycle.
REQ-034 i_rdata/d_rdata SHALL hold their value until the next read completion on that port.

Reset
REQ-035 reset=1 at a rising edge SHALL force state IDLE, last-grant = data, and all latches, rdata registers, acks and memory enables to 0.
REQ-036 Reset during SERVE: the access driven in that cycle completes at that edge (memory samples the same edge); no ack SHALL follow and no further memory access SHALL occur.
REQ-037 Reset SHALL take priority over all requests in the same cycle.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the FSM state encoding (IDLE/SERVE/RESP) and default width constants ADDR_W/DATA_W.
REQ-039 The two-way round-robin pick (inputs: i_req, d_req, last-grant; output: grant) SHALL be sub-module rr_arbiter2; all sequencing SHALL stay in mem_port_arbiter.

Verification
REQ-040 Fetch only: i_req=1, i_addr=0x8 from IDLE -> mem_read_en=1, mem_addr=0x8 in cycle N+1; i_ack=1, i_rdata=mem word at 0x8 in N+2.
REQ-041 Store then load: d_req, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_write_en one cycle, d_ack at N+2; then a load of 0x10 returns d_rdata=0xDEADBEEF.
REQ-042 Contention after reset: i_req=d_req=1 held -> fetch acked first, then data, then fetch again (strict alternation); i_ack and d_ack never coincident.
REQ-043 Early drop: d_req pulsed for one cycle only in IDLE -> d_ack still asserted at N+2.
REQ-044 Reset mid-op: reset=1 during a SERVE cycle -> no ack afterwards; state IDLE; all outputs 0 the cycle after.
REQ-045 Idle: no requests for 20 cycles -> mem_read_en=mem_write_en=0 and no acks throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// - ADDR_W / DATA_W : default address and data widths
// - ST_*            : FSM state encoding used by mem_port_arbiter
// - grant_e         : which requester owns the current transaction
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the fetch and data requesters.
// Ports:
//   i_req_i      - fetch request
//   d_req_i      - data request
//   last_grant_i - requester granted most recently
//   grant_o      - chosen requester (meaningful only when valid_o=1)
//   valid_o      - at least one request present
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  grant_e last_grant_i,
    output grant_e grant_o,
    output logic   valid_o
);

    always_comb begin
        grant_o = GNT_FETCH;
        if (i_req_i && d_req_i) begin
            // Contention: hand the port to whoever did not have it last.
            grant_o = (last_grant_i == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end else if (d_req_i) begin
            grant_o = GNT_DATA;
        end
    end

    assign valid_o = i_req_i | d_req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle memory port between an instruction-fetch port
// (read only) and a data port (load/store). Each transaction takes three
// cycles: grant in IDLE, memory access in SERVE, ack pulse in RESP.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, pick one, latch its address/we/wdata
// SERVE | drive the memory access; capture read data at the closing edge
// RESP  | one-cycle ack on the granted port
//
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   i_req, i_addr                - fetch request / address
//   i_ack, i_rdata               - fetch completion pulse / data
//   d_req, d_we, d_addr, d_wdata - data request, 1=store, address, data
//   d_ack, d_rdata               - data completion pulse / load data
//   mem_addr, mem_wdata          - latched memory address / write data
//   mem_read_en, mem_write_en    - memory strobes, active in SERVE only
//   mem_rdata                    - combinational memory read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    grant_e arb_grant;
    logic   arb_valid;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d        = arb_grant;
                    last_grant_d = arb_grant;
                    if (arb_grant == GNT_DATA) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        // Fetches never write; clear wdata so the bus is quiet.
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!we_q) begin
                    if (gnt_q == GNT_DATA) d_rdata_d = mem_rdata;
                    else                   i_rdata_d = mem_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_DATA;
            gnt_q        <= GNT_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_read_en  = (state_q == ST_SERVE) && !we_q;
    assign mem_write_en = (state_q == ST_SERVE) && we_q;
    assign i_ack        = (state_q == ST_RESP) && (gnt_q == GNT_FETCH);
    assign d_ack        = (state_q == ST_RESP) && (gnt_q == GNT_DATA);
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule
